usb_stream_bidir: RTL and testbench

- Parametrised FX2 slave-FIFO master. Successor to the single-direction stream-out block.
- Services one OUT endpoint (host->FPGA) and one IN endpoint (FPGA->host) on a shared FD bus, with round-robin arbitration and a per-direction burst limit.
- Commits partial IN packets on source idle-timeout using PKTEND.
- Sits between the FX2 pins, on fx2_ifclk, and internal stream logic.

---
 rtl/usb_stream_bidir.sv | 117 +++++++++++
 tb/tb_usb_stream_bidir.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_bidir.sv
// usb_stream_bidir: FX2 slave-FIFO master, round-robin OUT/IN service with burst limit and PKTEND on idle timeout; USB_STREAM_XFER_CNT_EN adds transfer counters.
module usb_stream_bidir #(
  parameter int         FIFO_WIDTH  = 16,
  parameter logic [1:0] OUT_EP_ADDR = 2'b00,
  parameter logic [1:0] IN_EP_ADDR  = 2'b10,
  parameter int         PKT_WORDS   = 256,
  parameter int         BURST_LEN   = 64,
  parameter int         PKT_TIMEOUT = 1024
) (
  input  logic                  fx2_ifclk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] fx2_fdata_in,
  output logic [FIFO_WIDTH-1:0] fx2_fdata_out,
  output logic                  fx2_fdata_oe,
  input  logic                  fx2_flagc,
  input  logic                  fx2_flagb,
  output logic [1:0]            fx2_faddr,
  output logic                  fx2_slrd,
  output logic                  fx2_slwr,
  output logic                  fx2_sloe,
  output logic                  fx2_pkt_end,
  output logic                  fx2_slcs,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  sink_ready,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready
`ifdef USB_STREAM_XFER_CNT_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic [15:0]           pe_count
`endif
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam int TW = $clog2(PKT_TIMEOUT + 1);
  if (FIFO_WIDTH != 8 && FIFO_WIDTH != 16) begin : g_bad_width
    $error("FIFO_WIDTH must be 8 or 16");
  end
  typedef enum logic [2:0] {IDLE, OUT_SEL, OUT_RD, IN_SEL, IN_WR, IN_PKTEND} state_t;
  state_t state, state_nx;
  logic [BW-1:0] burst_cnt;
  logic [PW-1:0] pkt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic last_in, pe_sel;
  logic want_out, want_in, want_pe, want_i, pick_out, rd, wr, pe_fire, burst_end, tmo_hit;
  assign tmo_hit   = tmo_cnt >= TW'(PKT_TIMEOUT) && pkt_cnt != '0;
  assign want_out  = fx2_flagc & sink_ready;
  assign want_in   = fx2_flagb & data_in_valid;
  assign want_pe   = fx2_flagb & ~data_in_valid & tmo_hit;
  assign want_i    = want_in | want_pe;
  assign pick_out  = want_out & (~want_i | last_in);
  assign rd        = state == OUT_RD && fx2_flagc && sink_ready;
  assign wr        = state == IN_WR && data_in_valid && fx2_flagb;
  assign pe_fire   = state == IN_PKTEND && fx2_flagb;
  assign burst_end = burst_cnt == BW'(BURST_LEN - 1);
  assign fx2_fdata_out = data_in;
  assign fx2_slcs      = 1'b0;
  always_ff @(posedge fx2_ifclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = pick_out ? OUT_SEL : want_i ? IN_SEL : IDLE;
      OUT_SEL:   state_nx = OUT_RD;
      OUT_RD:    state_nx = (!rd || burst_end) ? IDLE : OUT_RD;
      IN_SEL:    state_nx = pe_sel ? IN_PKTEND : IN_WR;
      IN_WR:     state_nx = (!wr || burst_end) ? IDLE : IN_WR;
      IN_PKTEND: state_nx = fx2_flagb ? IDLE : IN_PKTEND;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    fx2_sloe      = ~(state == OUT_SEL || state == OUT_RD);
    fx2_slrd      = ~rd;
    fx2_slwr      = ~wr;
    fx2_pkt_end   = ~pe_fire;
    fx2_fdata_oe  = state == IN_SEL || state == IN_WR;
    fx2_faddr     = (state == IN_SEL || state == IN_WR || state == IN_PKTEND) ? IN_EP_ADDR : OUT_EP_ADDR;
    data_in_ready = state == IN_WR && fx2_flagb;
  end
  // Timeout only runs while a partial packet is open; a committed or empty packet holds it at zero.
  always_ff @(posedge fx2_ifclk or posedge rst)
    if (rst) begin
      burst_cnt  <= '0;
      pkt_cnt    <= '0;
      tmo_cnt    <= '0;
      last_in    <= 1'b1;
      pe_sel     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd;
      if (rd) data_out <= fx2_fdata_in;
      if (state == IDLE) pe_sel <= want_pe;
      burst_cnt <= (state == OUT_SEL || state == IN_SEL) ? '0 : burst_cnt + BW'(rd | wr);
      if (state == OUT_RD && state_nx == IDLE) last_in <= 1'b0;
      if (state == IN_WR && state_nx == IDLE) last_in <= 1'b1;
      pkt_cnt <= pe_fire ? '0 : !wr ? pkt_cnt : pkt_cnt == PW'(PKT_WORDS - 1) ? '0 : pkt_cnt + PW'(1);
      tmo_cnt <= (pe_fire || wr || pkt_cnt == '0) ? '0 : tmo_cnt == TW'(PKT_TIMEOUT) ? tmo_cnt : tmo_cnt + TW'(1);
    end
`ifdef USB_STREAM_XFER_CNT_EN
  always_ff @(posedge fx2_ifclk or posedge rst)
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
      pe_count <= '0;
    end else begin
      rd_count <= rd_count + 32'(rd);
      wr_count <= wr_count + 32'(wr);
      pe_count <= pe_count + 16'(pe_fire);
    end
`endif
endmodule

// File: tb/tb_usb_stream_bidir.sv
// tb_usb_stream_bidir: scoreboard bench; FX2 FIFO/source model feeds the DUT, a negedge monitor pops expected words and PKTENDs.
module tb_usb_stream_bidir;
  localparam int W = 16, BL = 4, PT = 16, PW = 8;
  logic clk = 0, rst = 1;
  logic [W-1:0] fx2_fdata_in, fx2_fdata_out, data_out, data_in;
  logic fx2_fdata_oe, fx2_flagc, fx2_flagb, fx2_slrd, fx2_slwr, fx2_sloe, fx2_pkt_end, fx2_slcs;
  logic [1:0] fx2_faddr;
  logic data_valid, sink_ready, data_in_valid, data_in_ready;
`ifdef USB_STREAM_XFER_CNT_EN
  logic [31:0] rd_count, wr_count;
  logic [15:0] pe_count;
`endif
  usb_stream_bidir #(.FIFO_WIDTH(W), .PKT_WORDS(PW), .BURST_LEN(BL), .PKT_TIMEOUT(PT)) dut (
    .fx2_ifclk(clk), .rst(rst), .fx2_fdata_in(fx2_fdata_in), .fx2_fdata_out(fx2_fdata_out),
    .fx2_fdata_oe(fx2_fdata_oe), .fx2_flagc(fx2_flagc), .fx2_flagb(fx2_flagb), .fx2_faddr(fx2_faddr),
    .fx2_slrd(fx2_slrd), .fx2_slwr(fx2_slwr), .fx2_sloe(fx2_sloe), .fx2_pkt_end(fx2_pkt_end),
    .fx2_slcs(fx2_slcs), .data_out(data_out), .data_valid(data_valid), .sink_ready(sink_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready)
`ifdef USB_STREAM_XFER_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count), .pe_count(pe_count)
`endif
  );
  always #5 clk = ~clk;
  logic [W-1:0] out_q[$], src_q[$], exp_out[$], exp_in[$];
  int exp_pe[$];
  int checks = 0, failures = 0;
  bit out_en = 0, src_en = 0, burst_mode = 0, prev_rd = 0;
  int cyc = 0, cur_kind = 0, run_len = 0, last_run_kind = 0, runs = 0;
  int pe_seen = 0, last_wr_cyc = 0, pe_delta = 0, rd_total = 0, dv_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while ((exp_out.size() + exp_in.size() + exp_pe.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_pending"}, exp_out.size() + exp_in.size() + exp_pe.size(), 0);
  endtask
  task automatic wait_rd(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fx2_slrd && n < 100);
    chk({name, "_slrd_seen"}, fx2_slrd, 0);
  endtask
  // FX2 endpoint and stream-source model: decisions sampled mid-cycle, queues advanced just after the edge.
  initial begin
    bit rd_now, acc;
    fx2_flagc = 0; fx2_fdata_in = '0; data_in_valid = 0; data_in = '0;
    forever begin
      @(negedge clk);
      rd_now = !fx2_slrd && !rst;
      acc = data_in_valid && data_in_ready && !rst;
      @(posedge clk);
      #1;
      if (rd_now && out_q.size() > 0) void'(out_q.pop_front());
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      #1;
      fx2_flagc = out_en && out_q.size() > 0;
      fx2_fdata_in = out_q.size() > 0 ? out_q[0] : '0;
      data_in_valid = src_en && src_q.size() > 0;
      data_in = src_q.size() > 0 ? src_q[0] : '0;
    end
  end
  initial begin
    int kind;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_rd = 0; cur_kind = 0; run_len = 0;
      end else begin
        if (data_valid || prev_rd) chk("dv_latency", data_valid, prev_rd);
        if (data_valid) begin
          dv_total++;
          if (exp_out.size() == 0) chk("data_valid_extra", data_valid, 0);
          else chk("data_out", data_out, exp_out.pop_front());
        end
        if (!fx2_slrd) begin
          rd_total++;
          chk("rd_bus", {fx2_fdata_oe, fx2_sloe, fx2_faddr}, 4'b0000);
        end
        if (!fx2_slwr) begin
          chk("wr_bus", {fx2_fdata_oe, data_in_ready, fx2_faddr}, 4'b1110);
          if (exp_in.size() == 0) chk("slwr_extra", fx2_slwr, 1);
          else chk("fdata_out", fx2_fdata_out, exp_in.pop_front());
          last_wr_cyc = cyc;
        end
        if (!fx2_pkt_end) begin
          pe_seen++;
          pe_delta = cyc - last_wr_cyc;
          if (exp_pe.size() == 0) chk("pkt_end_extra", fx2_pkt_end, 1);
          else begin
            void'(exp_pe.pop_front());
            chk("pe_faddr", fx2_faddr, 2'b10);
          end
        end
        kind = !fx2_slrd ? 1 : !fx2_slwr ? 2 : 0;
        if (kind != cur_kind) begin
          if (cur_kind != 0 && burst_mode) begin
            chk("burst_len", run_len, BL);
            if (last_run_kind != 0) chk("burst_dir", cur_kind, last_run_kind == 1 ? 2 : 1);
            last_run_kind = cur_kind;
            runs++;
          end
          cur_kind = kind;
          run_len = kind != 0 ? 1 : 0;
        end else if (kind != 0) run_len++;
        prev_rd = !fx2_slrd;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, r0, d0;
    sink_ready = 0; fx2_flagb = 1;
    @(negedge clk);
    chk("rst_strobes", {fx2_slrd, fx2_slwr, fx2_sloe, fx2_pkt_end}, 4'hf);
    chk("rst_slcs", fx2_slcs, 0);
    chk("rst_faddr", fx2_faddr, 2'b00);
    chk("rst_oe", fx2_fdata_oe, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ready", data_in_ready, 0);
    tick();
    rst = 0;
    // OUT only: ten words
    sink_ready = 1; out_en = 1;
    r0 = rd_total; d0 = dv_total;
    for (int i = 0; i < 10; i++) begin out_q.push_back(16'hA000 + 16'(i)); exp_out.push_back(16'hA000 + 16'(i)); end
    wait_done("out_only", 200);
    repeat (2) @(negedge clk);
    chk("out_rd_count", rd_total - r0, 10);
    chk("out_dv_count", dv_total - d0, 10);
    tick();
    // backpressure mid-burst
    for (int i = 0; i < 6; i++) begin out_q.push_back(16'hB000 + 16'(i)); exp_out.push_back(16'hB000 + 16'(i)); end
    wait_rd("bp");
    tick();
    sink_ready = 0;
    @(negedge clk);
    chk("bp_slrd_same_cycle", fx2_slrd, 1);
    chk("bp_trailing_dv", data_valid, 1);
    @(negedge clk);
    chk("bp_dv_end", data_valid, 0);
    chk("bp_idle_sloe", fx2_sloe, 1);
    tick();
    sink_ready = 1;
    wait_done("bp_drain", 200);
    // IN full, then short packet committed by timeout
    fx2_flagb = 0; src_en = 1;
    for (int i = 0; i < 5; i++) begin src_q.push_back(16'hC000 + 16'(i)); exp_in.push_back(16'hC000 + 16'(i)); end
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_slwr", fx2_slwr, 1);
      chk("full_ready", data_in_ready, 0);
    end
    tick();
    fx2_flagb = 1;
    p0 = pe_seen;
    exp_pe.push_back(1);
    wait_done("short_pkt", 300);
    chk("short_pe_count", pe_seen - p0, 1);
    chk("short_pe_delay", pe_delta, 19);
    // PKTEND deferred while the IN endpoint is full
    for (int i = 0; i < 2; i++) begin src_q.push_back(16'hD000 + 16'(i)); exp_in.push_back(16'hD000 + 16'(i)); end
    wait_done("defer_wr", 200);
    fx2_flagb = 0;
    p0 = pe_seen;
    repeat (30) @(negedge clk);
    chk("defer_no_pe", pe_seen - p0, 0);
    tick();
    fx2_flagb = 1;
    exp_pe.push_back(1);
    wait_done("defer_pe", 100);
    chk("defer_pe_count", pe_seen - p0, 1);
    // full packet needs no PKTEND
    p0 = pe_seen;
    for (int i = 0; i < PW; i++) begin src_q.push_back(16'hE000 + 16'(i)); exp_in.push_back(16'hE000 + 16'(i)); end
    wait_done("full_pkt", 200);
    repeat (40) @(negedge clk);
    chk("full_no_pe", pe_seen - p0, 0);
    tick();
    // burst limit alternation
    runs = 0; last_run_kind = 0; burst_mode = 1;
    for (int i = 0; i < 8; i++) begin
      out_q.push_back(16'hF000 + 16'(i)); exp_out.push_back(16'hF000 + 16'(i));
      src_q.push_back(16'h5000 + 16'(i)); exp_in.push_back(16'h5000 + 16'(i));
    end
    wait_done("burst", 300);
    repeat (3) @(negedge clk);
    burst_mode = 0;
    chk("burst_runs", runs, 4);
    chk("burst_no_pe", pe_seen - p0, 0);
    tick();
    // asynchronous reset in the middle of OUT_RD
    for (int i = 0; i < 8; i++) begin out_q.push_back(16'h7000 + 16'(i)); exp_out.push_back(16'h7000 + 16'(i)); end
    wait_rd("arst");
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk("arst_strobes", {fx2_slrd, fx2_slwr, fx2_sloe, fx2_pkt_end}, 4'hf);
    chk("arst_oe", fx2_fdata_oe, 0);
    chk("arst_dv", data_valid, 0);
    chk("arst_data_out", data_out, 0);
    @(negedge clk);
    out_en = 0;
    out_q.delete();
    exp_out.delete();
    tick();
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {fx2_slrd, fx2_sloe, fx2_fdata_oe}, 3'b110);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
